pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt.
REQ-005 id_syscall  in  1  ID instruction is SYSCALL.
REQ-006 ex_mem_to_reg, ex_reg_write  in  1 each  EX instruction is a load / writes a register.
REQ-007 ex_wreg  in  5  destination register number of the EX instruction.
REQ-008 ex_redirect  in  1  EX resolved a taken beq/bne or a j/jal/jr (PC loads target this edge).
REQ-009 wb_syscall, wb_halt_cond  in  1 each  SYSCALL in WB / its $v0 selects halt.
REQ-010 resume  in  1  single-cycle pulse releasing HALT.
REQ-011 pc_en, ifid_en  out  1 each  PC / IF-ID register load enables.
REQ-012 ifid_flush, idex_flush  out  1 each  insert bubble into IF-ID / ID-EX on this edge.
REQ-013 halted  out  1  controller is in HALT.
REQ-014 cyc_cnt, stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-015 States RUN, DRAIN, HALT; stored state only; control outputs are combinational from state and current inputs.
REQ-016 lu = ex_mem_to_reg & ex_reg_write & (ex_wreg != 0) & ((id_use_rs & id_rs == ex_wreg) | (id_use_rt & id_rt == ex_wreg)).
REQ-017 RUN priority: ex_redirect > lu > id_syscall > normal.
REQ-018 RUN, ex_redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; state stays RUN even if id_syscall or lu.
REQ-019 RUN, lu (no redirect): pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; exactly one bubble per load-use pair.
REQ-020 RUN, id_syscall (no redirect, no lu): syscall advances to EX (outputs as normal), next state DRAIN.
REQ-021 RUN normal: pc_en=1, ifid_en=1, flushes 0.
REQ-022 DRAIN: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; remains until wb_syscall=1.
REQ-023 DRAIN with wb_syscall=1: next state HALT if wb_halt_cond=1, else RUN; pipeline resumes fetch the cycle after return to RUN.
REQ-024 HALT: pc_en=0, ifid_en=0, idex_flush=1, halted=1; resume=1 -> RUN next cycle; resume outside HALT ignored.
REQ-025 halted=0 in RUN and DRAIN.
REQ-026 cyc_cnt +1 every cycle state != HALT; stall_cnt +1 each RUN lu cycle without redirect; flush_cnt +1 each RUN ex_redirect cycle.
REQ-027 All counters saturate at 32'hFFFF_FFFF, never wrap.
REQ-028 Register $0 never triggers lu regardless of id_rs/id_rt.

Reset
REQ-029 rst=1 at a rising edge: state=RUN, all counters=0, regardless of current state (including mid-DRAIN/HALT).
REQ-030 During the rst cycle outputs follow RUN rules with registered state RUN thereafter; halted=0 from the first post-reset cycle.

Structure
REQ-031 Package pipeline_ctrl_pkg holds state enum (RUN=2'd0, DRAIN=2'd1, HALT=2'd2) and CNT_W=32.
REQ-032 One sub-module sat_counter (parameter width, inputs clk, rst, inc; output count) instantiated three times.
REQ-033 No other sub-modules; hazard and priority logic inline.

Verification
REQ-034 lw $8 in EX (ex_wreg=8), ID reads rs=8 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-035 ex_redirect=1 together with lu=1 and id_syscall=1 -> ifid_flush=idex_flush=1, pc_en=1, state RUN, flush_cnt+1, stall_cnt unchanged.
REQ-036 id_syscall in RUN, wb_syscall=1 with wb_halt_cond=1 three cycles later -> DRAIN 3 cycles, then halted=1; cyc_cnt frozen; resume pulse -> RUN, pc_en=1.
REQ-037 Same with wb_halt_cond=0 -> DRAIN then RUN, halted never 1.
REQ-038 ex_wreg=0, ex_mem_to_reg=1, id_rs=0 -> no stall; rst asserted in HALT -> next cycle RUN, all counters 0.
REQ-039 Force cyc_cnt to 32'hFFFF_FFFE, run 3 cycles -> holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/halt controller.
package pipeline_ctrl_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt controller for a 5-stage pipeline with performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_syscall,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_redirect,
  input  logic             wb_syscall,
  input  logic             wb_halt_cond,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state_q;
  state_t state_d;
  state_t cur_state;
  logic   load_use;
  logic   cyc_inc;
  logic   stall_inc;
  logic   flush_inc;

  // Load in EX feeding a register the ID instruction reads; $0 is never a hazard.
  assign load_use = ex_mem_to_reg && ex_reg_write && (ex_wreg != REG_W'(0)) &&
                    ((id_use_rs && (id_rs == ex_wreg)) ||
                     (id_use_rt && (id_rt == ex_wreg)));

  // While reset is asserted the controller behaves as if already in RUN.
  assign cur_state = rst ? RUN : state_q;
  assign cyc_inc   = (state_q != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    unique case (cur_state)
      RUN: begin
        state_d = RUN;
        if (ex_redirect) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          if (id_syscall) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        idex_flush = 1'b1;
        if (wb_syscall) begin
          state_d = wb_halt_cond ? HALT : RUN;
        end
      end
      HALT: begin
        idex_flush = 1'b1;
        halted     = 1'b1;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cyc_inc),
    .count (cyc_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
